card_dealer_writer: RTL and testbench



---
 rtl/card_dealer_writer_if.sv | 36 +++
 rtl/card_dealer_writer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_card_dealer_writer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_writer_if.sv
// card_dealer_writer_if
//   Groups the game-side control inputs and the regfile write-request
//   outputs of card_dealer_writer.
//   master : the dealer (drives write buses and status, receives controls)
//   slave  : the consumer/stimulus side (drives controls, receives writes)
//   Signals:
//     new_game       1  start/restart pulse
//     flip_req       1  player flip pulse
//     flip_addr      4  card address for flip_req
//     write_data_1  19  {data[13:0], addr[3:0], en}
//     write_data_2   7  {card_state[1:0], addr[3:0], en}
//     read_all_cards 1  full readback request pulse
//     busy           1  high outside IDLE/PLAY
//     pairs_found    3  matched pairs
//     game_over      1  all pairs matched
interface card_dealer_writer_if;
  logic        new_game;
  logic        flip_req;
  logic [3:0]  flip_addr;
  logic [18:0] write_data_1;
  logic [6:0]  write_data_2;
  logic        read_all_cards;
  logic        busy;
  logic [2:0]  pairs_found;
  logic        game_over;

  modport master (
    input  new_game, flip_req, flip_addr,
    output write_data_1, write_data_2, read_all_cards, busy, pairs_found, game_over
  );

  modport slave (
    output new_game, flip_req, flip_addr,
    input  write_data_1, write_data_2, read_all_cards, busy, pairs_found, game_over
  );
endinterface

// File: rtl/card_dealer_writer.sv
// card_dealer_writer
//   Shuffles and deals NUM_CARDS cards (pairs of symbols) into the card
//   register file, applies player flips and resolves each flipped pair to
//   MATCHED or back to HIDDEN after HOLD_CYCLES.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : card_dealer_writer_if.master (controls in, write requests out)
//   Optional build macro DEAL_PREVIEW_EN: after the deal, show every card
//   face up for PREVIEW_CYCLES, then hide them again before play starts.
module card_dealer_writer #(
  parameter int unsigned NUM_CARDS      = 12,
  parameter int unsigned HOLD_CYCLES    = 65_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned PREVIEW_CYCLES = 130_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  card_dealer_writer_if.master bus
);

  localparam logic [3:0]  LAST_ADDR = 4'(NUM_CARDS);
  localparam logic [2:0]  PAIRS_MAX = 3'(NUM_CARDS / 2);
  localparam int unsigned CNT_MAX   = (PREVIEW_CYCLES > HOLD_CYCLES) ? PREVIEW_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
`ifdef DEAL_PREVIEW_EN
  localparam logic [CNT_W-1:0] PREV_LAST = CNT_W'(PREVIEW_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    CS_HIDDEN  = 2'b00,
    CS_FACE_UP = 2'b01,
    CS_MATCHED = 2'b10
  } card_state_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SHUFFLE,
    S_DEAL,
    S_DEALT,
    S_PLAY,
    S_HOLD,
    S_RESOLVE_A,
    S_RESOLVE_B
`ifdef DEAL_PREVIEW_EN
    , S_PREV_UP,
    S_PREV_WAIT,
    S_PREV_DOWN
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [2:0]       sym_q [NUM_CARDS];
  logic [2:0]       sym_d [NUM_CARDS];
  card_state_e      cst_q [NUM_CARDS];
  card_state_e      cst_d [NUM_CARDS];
  logic [3:0]       idx_q, idx_d;        // shuffle position i, then deal/preview address
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic             have_a_q, have_a_d;
  logic             flip_wr_q, flip_wr_d;
  logic [3:0]       flip_addr_q, flip_addr_d;
  logic [2:0]       pairs_q, pairs_d;
  logic             over_q, over_d;

  logic [3:0]       cand;
  logic             swap;
  logic             flip_in_range;
  logic [3:0]       flip_idx;
  logic             flip_ok;
  logic             is_match;
  card_state_e      res_state;
  logic             last_addr;
  logic [3:0]       idx_next;
  logic [2:0]       pairs_inc;

  always_comb begin
    cand          = lfsr_q[3:0];
    swap          = (cand <= idx_q);
    flip_in_range = (bus.flip_addr != 4'd0) && (bus.flip_addr <= LAST_ADDR);
    flip_idx      = flip_in_range ? (bus.flip_addr - 4'd1) : 4'd0;
    flip_ok       = bus.flip_req && flip_in_range && (cst_q[flip_idx] == CS_HIDDEN);
    is_match      = (sym_q[a_q - 4'd1] == sym_q[b_q - 4'd1]);
    res_state     = is_match ? CS_MATCHED : CS_HIDDEN;
    last_addr     = (idx_q == LAST_ADDR);
    idx_next      = last_addr ? 4'd1 : (idx_q + 4'd1);
    pairs_inc     = pairs_q + 3'd1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; new_game overrides every state
  always_comb begin
    state_d = state_q;
    if (bus.new_game) begin
      state_d = S_SHUFFLE;
    end else begin
      unique case (state_q)
        S_IDLE:      state_d = S_IDLE;
        S_SHUFFLE:   if (swap && (idx_q == 4'd1)) state_d = S_DEAL;
`ifdef DEAL_PREVIEW_EN
        S_DEAL:      if (last_addr) state_d = S_PREV_UP;
        S_PREV_UP:   if (last_addr) state_d = S_PREV_WAIT;
        S_PREV_WAIT: if (cnt_q == PREV_LAST) state_d = S_PREV_DOWN;
        S_PREV_DOWN: if (last_addr) state_d = S_DEALT;
`else
        S_DEAL:      if (last_addr) state_d = S_DEALT;
`endif
        S_DEALT:     state_d = S_PLAY;
        S_PLAY:      if (flip_ok && have_a_q) state_d = S_HOLD;
        S_HOLD:      if (cnt_q == HOLD_LAST) state_d = S_RESOLVE_A;
        S_RESOLVE_A: state_d = S_RESOLVE_B;
        S_RESOLVE_B: state_d = (is_match && (pairs_inc == PAIRS_MAX)) ? S_IDLE : S_PLAY;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: LFSR, shadow array, flip bookkeeping, counters
  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    sym_d       = sym_q;
    cst_d       = cst_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    have_a_d    = have_a_q;
    flip_wr_d   = 1'b0;
    flip_addr_d = '0;
    pairs_d     = pairs_q;
    over_d      = over_q;
    if (bus.new_game) begin
      for (int unsigned k = 0; k < NUM_CARDS; k++) begin
        sym_d[4'(k)] = 3'(k >> 1);
        cst_d[4'(k)] = CS_HIDDEN;
      end
      idx_d    = LAST_ADDR - 4'd1;
      cnt_d    = '0;
      have_a_d = 1'b0;
      over_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_SHUFFLE: begin
          if (swap) begin
            sym_d[idx_q] = sym_q[cand];
            sym_d[cand]  = sym_q[idx_q];
            idx_d        = (idx_q == 4'd1) ? 4'd1 : (idx_q - 4'd1);
          end
        end
        S_DEAL: begin
          cst_d[idx_q - 4'd1] = CS_HIDDEN;
          idx_d               = idx_next;
          cnt_d               = '0;
        end
`ifdef DEAL_PREVIEW_EN
        S_PREV_UP: begin
          cst_d[idx_q - 4'd1] = CS_FACE_UP;
          idx_d               = idx_next;
          cnt_d               = '0;
        end
        S_PREV_WAIT: cnt_d = cnt_q + CNT_W'(1);
        S_PREV_DOWN: begin
          cst_d[idx_q - 4'd1] = CS_HIDDEN;
          idx_d               = idx_next;
        end
`endif
        S_DEALT: begin
          pairs_d  = '0;
          have_a_d = 1'b0;
        end
        S_PLAY: begin
          if (flip_ok) begin
            cst_d[flip_idx] = CS_FACE_UP;
            flip_wr_d       = 1'b1;
            flip_addr_d     = bus.flip_addr;
            cnt_d           = '0;
            if (have_a_q) begin
              b_d = bus.flip_addr;
            end else begin
              a_d      = bus.flip_addr;
              have_a_d = 1'b1;
            end
          end
        end
        // The first HOLD cycle carries card B's face-up write, so counting
        // 0..HOLD_CYCLES leaves HOLD_CYCLES quiet cycles with both cards shown.
        S_HOLD:      cnt_d = cnt_q + CNT_W'(1);
        S_RESOLVE_A: cst_d[a_q - 4'd1] = res_state;
        S_RESOLVE_B: begin
          cst_d[b_q - 4'd1] = res_state;
          have_a_d          = 1'b0;
          if (is_match) begin
            pairs_d = pairs_inc;
            if (pairs_inc == PAIRS_MAX) over_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= LFSR_SEED;
      for (int unsigned k = 0; k < NUM_CARDS; k++) begin
        sym_q[4'(k)] <= '0;
        cst_q[4'(k)] <= CS_HIDDEN;
      end
      idx_q       <= '0;
      cnt_q       <= '0;
      a_q         <= 4'd1;
      b_q         <= 4'd1;
      have_a_q    <= 1'b0;
      flip_wr_q   <= 1'b0;
      flip_addr_q <= '0;
      pairs_q     <= '0;
      over_q      <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      sym_q       <= sym_d;
      cst_q       <= cst_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      have_a_q    <= have_a_d;
      flip_wr_q   <= flip_wr_d;
      flip_addr_q <= flip_addr_d;
      pairs_q     <= pairs_d;
      over_q      <= over_d;
    end
  end

  // Output logic: state-driven writes; a pending flip write only ever
  // occurs in PLAY/first HOLD cycle, so it never collides with them.
  always_comb begin
    bus.write_data_1   = '0;
    bus.write_data_2   = '0;
    bus.read_all_cards = 1'b0;
    unique case (state_q)
      S_DEAL:      bus.write_data_1 = {9'b0, sym_q[idx_q - 4'd1], CS_HIDDEN, idx_q, 1'b1};
`ifdef DEAL_PREVIEW_EN
      S_PREV_UP:   bus.write_data_2 = {CS_FACE_UP, idx_q, 1'b1};
      S_PREV_DOWN: bus.write_data_2 = {CS_HIDDEN, idx_q, 1'b1};
`endif
      S_DEALT:     bus.read_all_cards = 1'b1;
      S_RESOLVE_A: bus.write_data_2 = {res_state, a_q, 1'b1};
      S_RESOLVE_B: bus.write_data_2 = {res_state, b_q, 1'b1};
      default: ;
    endcase
    if (flip_wr_q) bus.write_data_2 = {CS_FACE_UP, flip_addr_q, 1'b1};
    bus.busy        = (state_q != S_IDLE) && (state_q != S_PLAY);
    bus.pairs_found = pairs_q;
    bus.game_over   = over_q;
  end

endmodule

// File: tb/tb_card_dealer_writer.sv
// tb_card_dealer_writer
//   Directed bench for card_dealer_writer (HOLD_CYCLES = 4): deal contents,
//   flip acceptance/rejection, match and mismatch resolution timing, a full
//   game to game_over, new_game abort during HOLD and reset during DEAL.
module tb_card_dealer_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  card_dealer_writer_if bus ();

  card_dealer_writer #(.HOLD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bus monitor, sampled on the falling edge
  int cyc = 0, rd_cnt = 0, rd_cyc = 0, both_cnt = 0, idle_bus_cnt = 0;
  logic [18:0] w1_q [$];
  int          w1_cyc [$];
  logic [6:0]  w2_q [$];
  int          w2_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.write_data_1[0]) begin w1_q.push_back(bus.write_data_1); w1_cyc.push_back(cyc); end
      if (bus.write_data_2[0]) begin w2_q.push_back(bus.write_data_2); w2_cyc.push_back(cyc); end
      if (bus.read_all_cards) begin rd_cnt++; rd_cyc = cyc; end
      if (bus.write_data_1[0] && bus.write_data_2[0]) both_cnt++;
      if (!bus.write_data_1[0] && bus.write_data_1 != 19'd0) idle_bus_cnt++;
      if (!bus.write_data_2[0] && bus.write_data_2 != 7'd0) idle_bus_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int sym [16];
  bit matched [16];

  function automatic logic [6:0] mk2(input logic [1:0] st, input int a);
    logic [3:0] a4;
    a4 = 4'(a);
    return {st, a4, 1'b1};
  endfunction

  function automatic logic [6:0] w2_at(input int i);
    return (i < w2_q.size()) ? w2_q[i] : 7'h00;
  endfunction

  function automatic int c2_at(input int i);
    return (i < w2_cyc.size()) ? w2_cyc[i] : -100;
  endfunction

  function automatic int partner(input int a);
    for (int b = 1; b <= 12; b++) if (b != a && sym[b] == sym[a]) return b;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_new();
    tick(); bus.new_game = 1'b1;
    tick(); bus.new_game = 1'b0;
  endtask

  task automatic flip(input int a);
    tick(); bus.flip_req = 1'b1; bus.flip_addr = 4'(a);
    tick(); bus.flip_req = 1'b0; bus.flip_addr = 4'd0;
  endtask

  task automatic clear_logs();
    w1_q.delete(); w1_cyc.delete(); w2_q.delete(); w2_cyc.delete(); rd_cnt = 0;
  endtask

  task automatic expect_deal();
    int cnt [8];
    int n;
    int s;
    n = 0;
    while (rd_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    check("deal_done", 32'(rd_cnt), 32'd1);
    check("deal_count", 32'(w1_q.size()), 32'd12);
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int i = 0; i < w1_q.size(); i++) begin
      check("deal_addr", 32'(w1_q[i][4:1]), 32'(i + 1));
      check("deal_state", 32'(w1_q[i][6:5]), 32'd0);
      check("deal_pad", 32'(w1_q[i][18:10]), 32'd0);
      s = int'(w1_q[i][9:7]);
      sym[w1_q[i][4:1]] = s;
      cnt[s]++;
    end
    for (int i = 0; i < 6; i++) check("deal_sym_twice", 32'(cnt[i]), 32'd2);
    check("deal_rd_timing", 32'(rd_cyc - ((w1_cyc.size() > 0) ? w1_cyc[w1_cyc.size() - 1] : 0)), 32'd1);
    check("deal_busy_low", 32'(bus.busy), 32'd0);
    check("deal_pairs0", 32'(bus.pairs_found), 32'd0);
    for (int i = 0; i < 16; i++) matched[i] = 1'b0;
  endtask

  initial begin
    int p, q, x, y, b, n, n_at_rst;
    bus.new_game = 1'b0; bus.flip_req = 1'b0; bus.flip_addr = 4'd0;
    idle(3);
    check("rst_wd1", 32'(bus.write_data_1), 32'd0);
    check("rst_wd2", 32'(bus.write_data_2), 32'd0);
    check("rst_rd", 32'(bus.read_all_cards), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pairs", 32'(bus.pairs_found), 32'd0);
    check("rst_over", 32'(bus.game_over), 32'd0);
    rst = 1'b0;

    // First deal
    clear_logs();
    pulse_new();
    check("busy_after_new", 32'(bus.busy), 32'd1);
    expect_deal();

    // Flip 3 twice, then out-of-range flips
    clear_logs();
    flip(3); flip(3); idle(4);
    check("flip3_count", 32'(w2_q.size()), 32'd1);
    check("flip3_word", 32'(w2_at(0)), 32'h27);
    flip(0); flip(13); idle(4);
    check("flip_oob", 32'(w2_q.size()), 32'd1);
    check("flip_oob_wd1", 32'(w1_q.size()), 32'd0);

    // Matching pair with card 3 as A; a flip during HOLD is ignored
    p = partner(3);
    q = 1;
    while (q == 3 || q == p) q++;
    flip(p); flip(q); idle(12);
    check("match_count", 32'(w2_q.size()), 32'd4);
    check("match_fu_b", 32'(w2_at(1)), 32'(mk2(2'b01, p)));
    check("match_a", 32'(w2_at(2)), 32'(mk2(2'b10, 3)));
    check("match_b", 32'(w2_at(3)), 32'(mk2(2'b10, p)));
    check("hold_gap", 32'(c2_at(2) - c2_at(1)), 32'd5);
    check("resolve_gap", 32'(c2_at(3) - c2_at(2)), 32'd1);
    check("pairs_1", 32'(bus.pairs_found), 32'd1);
    matched[3] = 1'b1; matched[p] = 1'b1;

    // Mismatched pair
    x = 1;
    while (matched[x]) x++;
    y = 1;
    while (matched[y] || sym[y] == sym[x]) y++;
    clear_logs();
    flip(x); flip(y); idle(12);
    check("mis_count", 32'(w2_q.size()), 32'd4);
    check("mis_hide_a", 32'(w2_at(2)), 32'(mk2(2'b00, x)));
    check("mis_hide_b", 32'(w2_at(3)), 32'(mk2(2'b00, y)));
    check("mis_pairs", 32'(bus.pairs_found), 32'd1);
    clear_logs();
    flip(x); idle(2);
    check("reflip", 32'(w2_at(0)), 32'(mk2(2'b01, x)));
    b = partner(x);
    flip(b); idle(12);
    check("pairs_2", 32'(bus.pairs_found), 32'd2);
    matched[x] = 1'b1; matched[b] = 1'b1;

    // Finish the game
    for (int a = 1; a <= 12; a++) begin
      if (!matched[a]) begin
        b = partner(a);
        flip(a); flip(b); idle(12);
        matched[a] = 1'b1; matched[b] = 1'b1;
      end
    end
    check("end_pairs", 32'(bus.pairs_found), 32'd6);
    check("end_over", 32'(bus.game_over), 32'd1);
    check("end_idle", 32'(bus.busy), 32'd0);
    clear_logs();
    flip(1); flip(5); idle(4);
    check("end_no_writes", 32'(w2_q.size()), 32'd0);

    // new_game during HOLD
    clear_logs();
    pulse_new();
    check("over_cleared", 32'(bus.game_over), 32'd0);
    expect_deal();
    clear_logs();
    flip(1); flip(2); idle(2);
    pulse_new();
    expect_deal();
    check("abort_no_resolve", 32'(w2_q.size()), 32'd2);

    // Reset in the middle of DEAL
    clear_logs();
    pulse_new();
    n = 0;
    while (w1_q.size() < 3 && n < 3000) begin @(negedge clk); n++; end
    check("rst_deal_started", 32'(w1_q.size() >= 3), 32'd1);
    #2 rst = 1'b1;
    #1;
    n_at_rst = w1_q.size();
    check("arst_wd1", 32'(bus.write_data_1), 32'd0);
    check("arst_wd2", 32'(bus.write_data_2), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_pairs", 32'(bus.pairs_found), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(20);
    check("arst_deal_stopped", 32'(w1_q.size()), 32'(n_at_rst));
    check("arst_no_rd", 32'(rd_cnt), 32'd0);
    check("arst_idle", 32'(bus.busy), 32'd0);

    check("en_exclusive", 32'(both_cnt), 32'd0);
    check("idle_fields_zero", 32'(idle_bus_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
